// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types and constants for the universal shift register family
//
// Holds the deserializer FSM state type, the USR mode encoding shared with
// the shift register itself, and the bit-counter width helper.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  // Counter must be able to hold the value WIDTH itself (parity phase).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_deser_shreg.sv
// rtl/usr_deser_shreg.sv - bidirectional shift register with enable and clear
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : shift one bit this cycle
//   clr        : discard current contents (applied before any shift)
//   lsb_first  : 1 = shift right (s_in enters at MSB), 0 = shift left
//   s_in       : serial bit
//   q_next     : value the register takes on the next edge
module usr_deser_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             lsb_first,
  input  logic             s_in,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] base;

  // The next value is exported so the word containing the final bit can be
  // captured on the same edge that shifts that bit in.
  always_comb begin
    base   = clr ? '0 : q;
    q_next = base;
    if (en) begin
      if (lsb_first) q_next = {s_in, base[WIDTH-1:1]};
      else           q_next = {base[WIDTH-2:0], s_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule

// File: rtl/usr_deser.sv
// rtl/usr_deser.sv - serial-to-parallel receiver for USR serial outputs
//
// Optional feature macro: USR_DESER_PARITY_EN (even-parity bit after data).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   s_in, s_valid       : serial bit and its qualifier
//   sync                : frame start, drops any partial word
//   lsb_first           : stream order, latched on the first bit of a word
//   p_out, p_valid      : assembled word and its valid flag
//   p_ready             : consumer accepts p_out
//   busy                : word partially received
//   overrun, clr_ovr    : sticky dropped-word flag and its clear
//   parity_err          : parity mismatch on current p_out (0 without parity)
module usr_deser
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             sync,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);

  deser_state_t     state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             dir_q, dir_n;
  logic             first;
  logic             complete;
  logic             shift_en;
  logic             shift_dir;
  logic [WIDTH-1:0] word;
  logic             drop;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dir_n    = dir_q;
    first    = 1'b0;
    complete = 1'b0;
    if (sync) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
    if (s_valid) begin
      // A bit arriving with sync, or from IDLE, starts a fresh word.
      if (sync || state == IDLE) begin
        first   = 1'b1;
        dir_n   = lsb_first;
        state_n = DATA;
        cnt_n   = CW'(1);
      end else if (state == DATA) begin
        if (cnt == CW'(WIDTH - 1)) begin
`ifdef USR_DESER_PARITY_EN
          state_n = PARITY;
          cnt_n   = CW'(WIDTH);
`else
          complete = 1'b1;
          state_n  = IDLE;
          cnt_n    = '0;
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end else begin
        complete = 1'b1;
        state_n  = IDLE;
        cnt_n    = '0;
      end
    end
  end

  // The first bit must use the live lsb_first; dir_q is not loaded yet.
  assign shift_en  = s_valid && (first || state == DATA);
  assign shift_dir = first ? lsb_first : dir_q;
  assign drop      = complete && p_valid && !p_ready;
  assign busy      = (state != IDLE);

  usr_deser_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .en        (shift_en),
    .clr       (sync),
    .lsb_first (shift_dir),
    .s_in      (s_in),
    .q_next    (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dir_q   <= 1'b0;
      p_out   <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dir_q <= dir_n;
      if (complete && (!p_valid || p_ready)) begin
        p_out   <= word;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

`ifdef USR_DESER_PARITY_EN
  // In PARITY the register is not shifting, so word holds the data bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (complete && (!p_valid || p_ready)) begin
      parity_err <= (^word) ^ s_in;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_usr_deser.sv
// tb/tb_usr_deser.sv - self-checking bench for usr_deser
module tb_usr_deser;

  localparam int W = 4;
`ifdef USR_DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, s_in, s_valid, sync, lsb_first, p_ready, clr_ovr;
  logic [W-1:0] p_out;
  logic         p_valid, busy, overrun, parity_err;

  always #5 clk = ~clk;

  usr_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_in       (s_in),
    .s_valid    (s_valid),
    .sync       (sync),
    .lsb_first  (lsb_first),
    .p_out      (p_out),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .busy       (busy),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .parity_err (parity_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: bits received so far in arrival order, plus output state.
  bit         cur[$];
  bit         m_dir;
  logic [W-1:0] m_out   = '0;
  bit         m_valid = 0;
  bit         m_ovr   = 0;
  bit         m_perr  = 0;

  task automatic step(input bit r, input bit sv, input bit si, input bit sy,
                      input bit lf, input bit rdy, input bit co);
    bit           done;
    bit           pe;
    bit           was_valid;
    logic [W-1:0] w;
    rst = r; s_valid = sv; s_in = si; sync = sy; lsb_first = lf;
    p_ready = rdy; clr_ovr = co;
    @(posedge clk);
    cyc++;
    if (r) begin
      cur.delete();
      m_out = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
    end else begin
      done = 0; pe = 0; w = '0;
      was_valid = m_valid;
      if (sy) cur.delete();
      if (sv) begin
        if (cur.size() == 0) m_dir = lf;
        cur.push_back(si);
        if (cur.size() == W + PAR) begin
          for (int i = 0; i < W; i++) w[m_dir ? i : W - 1 - i] = cur[i];
          foreach (cur[i]) pe ^= cur[i];
          done = 1;
          cur.delete();
        end
      end
      if (done && was_valid && !rdy) m_ovr = 1;
      else if (co)                   m_ovr = 0;
      if (done && (!was_valid || rdy)) begin
        m_out = w; m_valid = 1; m_perr = (PAR != 0) ? pe : 1'b0;
      end else if (was_valid && rdy) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic send_word(input bit b0, input bit b1, input bit b2, input bit b3,
                           input bit lf, input bit rdy, input bit flip);
    step(0, 1, b0, 0, lf, rdy, 0);
    step(0, 1, b1, 0, lf, rdy, 0);
    step(0, 1, b2, 0, lf, rdy, 0);
    step(0, 1, b3, 0, lf, rdy, 0);
    if (PAR != 0) step(0, 1, b0 ^ b1 ^ b2 ^ b3 ^ flip, 0, lf, rdy, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({p_out, p_valid, busy, overrun, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got p_out=%b v=%b busy=%b ovr=%b perr=%b, expected all 0",
               p_out, p_valid, busy, overrun, parity_err);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (p_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b busy=%b, expected 0 0", p_valid, busy);
    end
  endtask

  task automatic test_lsb();
    send_word(1, 0, 1, 1, 1, 1, 0);
    n_checks++;
    if (p_out !== 4'b1101 || p_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_word: got %b v=%b, expected 1101 v=1", p_out, p_valid);
    end
    step(0, 0, 0, 0, 1, 1, 0);
    n_checks++;
    if (p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_pulse: got v=%b, expected 0", p_valid);
    end
  endtask

  task automatic test_msb_back_to_back();
    int c1;
    send_word(1, 0, 1, 1, 0, 1, 0);
    c1 = cyc;
    n_checks++;
    if (p_out !== 4'b1011 || p_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_word1: got %b v=%b, expected 1011 v=1", p_out, p_valid);
    end
    step(0, 1, 0, 0, 0, 1, 0);
    n_checks++;
    if (p_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_gap: got v=%b busy=%b, expected 0 1", p_valid, busy);
    end
    step(0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    if (PAR != 0) step(0, 1, 0, 0, 0, 1, 0);
    n_checks++;
    if (p_out !== 4'b0110 || p_valid !== 1'b1 || (cyc - c1) != W + PAR) begin
      n_fail++;
      $display("FAIL msb_word2: got %b v=%b after %0d cycles, expected 0110 v=1 after %0d",
               p_out, p_valid, cyc - c1, W + PAR);
    end
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_overrun();
    send_word(0, 1, 0, 1, 1, 0, 0);
    send_word(1, 0, 1, 0, 1, 0, 0);
    n_checks++;
    if (p_out !== 4'hA || overrun !== 1'b1 || p_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: got p_out=%h ovr=%b v=%b, expected A 1 1", p_out, overrun, p_valid);
    end
    step(0, 0, 0, 0, 1, 0, 1);
    n_checks++;
    if (overrun !== 1'b0 || p_valid !== 1'b1 || p_out !== 4'hA) begin
      n_fail++;
      $display("FAIL ovr_clear: got ovr=%b v=%b p_out=%h, expected 0 1 A", overrun, p_valid, p_out);
    end
    step(0, 0, 0, 0, 1, 1, 0);
    n_checks++;
    if (p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drain: got v=%b, expected 0", p_valid);
    end
  endtask

  task automatic test_sync();
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_busy: got %b, expected 1", busy);
    end
    step(0, 0, 0, 1, 1, 1, 0);
    n_checks++;
    if (busy !== 1'b0 || p_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_discard: got busy=%b v=%b, expected 0 0", busy, p_valid);
    end
    send_word(0, 0, 1, 1, 1, 1, 0);
    n_checks++;
    if (p_out !== 4'b1100 || overrun !== 1'b0 || p_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_word: got %b ovr=%b v=%b, expected 1100 0 1", p_out, overrun, p_valid);
    end
    step(0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic test_rst_mid();
    send_word(0, 1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);
    n_checks++;
    if ({p_out, p_valid, busy, overrun, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got p_out=%b v=%b busy=%b ovr=%b perr=%b, expected all 0",
               p_out, p_valid, busy, overrun, parity_err);
    end
    send_word(1, 1, 1, 1, 1, 1, 0);
    n_checks++;
    if (p_out !== 4'hF || p_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_word: got %h v=%b, expected F 1", p_out, p_valid);
    end
    step(0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic test_dir_latch();
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    if (PAR != 0) step(0, 1, 1, 0, 0, 1, 0);
    n_checks++;
    if (p_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL dir_latch: got %b, expected 0001", p_out);
    end
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

`ifdef USR_DESER_PARITY_EN
  task automatic test_parity();
    send_word(1, 0, 1, 1, 1, 1, 0);
    n_checks++;
    if (parity_err !== 1'b0 || p_out !== 4'b1101) begin
      n_fail++;
      $display("FAIL parity_good: got perr=%b p_out=%b, expected 0 1101", parity_err, p_out);
    end
    send_word(1, 0, 1, 1, 1, 1, 1);
    n_checks++;
    if (parity_err !== 1'b1 || p_out !== 4'b1101) begin
      n_fail++;
      $display("FAIL parity_bad: got perr=%b p_out=%b, expected 1 1101", parity_err, p_out);
    end
    step(0, 0, 0, 0, 1, 1, 0);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      n_checks++;
      if (p_out !== m_out || p_valid !== m_valid || busy !== (cur.size() != 0) ||
          overrun !== m_ovr || parity_err !== m_perr) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got p_out=%b v=%b busy=%b ovr=%b perr=%b, expected %b %b %b %b %b",
                 n, p_out, p_valid, busy, overrun, parity_err,
                 m_out, m_valid, cur.size() != 0, m_ovr, m_perr);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lsb();
    test_msb_back_to_back();
    test_overrun();
    test_sync();
    test_rst_mid();
    test_dir_latch();
`ifdef USR_DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
